// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared scheduler/fetcher state encodings and program memory defaults
package gpu_pkg;

    localparam int DEF_PROGRAM_MEM_ADDR_BITS = 8;
    localparam int DEF_PROGRAM_MEM_DATA_BITS = 16;
    localparam int DEF_ICACHE_ENTRIES        = 4;

    typedef enum logic [2:0] {
        CS_IDLE    = 3'b000,
        CS_FETCH   = 3'b001,
        CS_DECODE  = 3'b010,
        CS_REQUEST = 3'b011,
        CS_WAIT    = 3'b100,
        CS_EXECUTE = 3'b101,
        CS_UPDATE  = 3'b110,
        CS_DONE    = 3'b111
    } core_state_t;

    typedef enum logic [2:0] {
        FS_IDLE     = 3'b000,
        FS_FETCHING = 3'b001,
        FS_FETCHED  = 3'b010
    } fetcher_state_t;

endpackage

// File: rtl/fetcher_icache.sv
// rtl/fetcher_icache.sv - direct-mapped instruction cache used by fetcher when FETCHER_ICACHE_EN is defined
module fetcher_icache
    import gpu_pkg::*;
#(
    parameter int ADDR_BITS = DEF_PROGRAM_MEM_ADDR_BITS,
    parameter int DATA_BITS = DEF_PROGRAM_MEM_DATA_BITS,
    parameter int ENTRIES   = DEF_ICACHE_ENTRIES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] i_lookup_pc,
    output logic                 o_hit,
    output logic [DATA_BITS-1:0] o_data,
    input  logic                 i_fill_we,
    input  logic [ADDR_BITS-1:0] i_fill_pc,
    input  logic [DATA_BITS-1:0] i_fill_data
);

    localparam int INDEX_BITS = $clog2(ENTRIES);
    localparam int TAG_BITS   = ADDR_BITS - INDEX_BITS;

    logic [ENTRIES-1:0]   r_valid;
    logic [TAG_BITS-1:0]  r_tag  [ENTRIES];
    logic [DATA_BITS-1:0] r_data [ENTRIES];

    logic [INDEX_BITS-1:0] w_lookup_idx;
    logic [TAG_BITS-1:0]   w_lookup_tag;
    logic [INDEX_BITS-1:0] w_fill_idx;
    logic [TAG_BITS-1:0]   w_fill_tag;

    assign w_lookup_idx = i_lookup_pc[INDEX_BITS-1:0];
    assign w_lookup_tag = i_lookup_pc[ADDR_BITS-1:INDEX_BITS];
    assign w_fill_idx   = i_fill_pc[INDEX_BITS-1:0];
    assign w_fill_tag   = i_fill_pc[ADDR_BITS-1:INDEX_BITS];

    assign o_hit  = r_valid[w_lookup_idx] && (r_tag[w_lookup_idx] == w_lookup_tag);
    assign o_data = r_data[w_lookup_idx];

    // Valid bits: cleared by reset, set when a memory response fills the line.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else if (i_fill_we) begin
            r_valid[w_fill_idx] <= 1'b1;
        end
    end

    // Tag/data storage: a fill coinciding with reset is dropped so an abandoned miss leaves no trace.
    always_ff @(posedge clk) begin
        if (!reset && i_fill_we) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= i_fill_data;
        end
    end

endmodule

// File: rtl/fetcher.sv
// rtl/fetcher.sv - per-core instruction fetcher; FETCHER_ICACHE_EN adds a direct-mapped instruction cache
module fetcher
    import gpu_pkg::*;
#(
    parameter int PROGRAM_MEM_ADDR_BITS = DEF_PROGRAM_MEM_ADDR_BITS,
    parameter int PROGRAM_MEM_DATA_BITS = DEF_PROGRAM_MEM_DATA_BITS,
    parameter int ICACHE_ENTRIES        = DEF_ICACHE_ENTRIES
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

    fetcher_state_t                   r_state;
    fetcher_state_t                   w_next_state;
    logic                             r_valid;
    logic                             w_next_valid;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] r_addr;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] w_next_addr;
    logic [PROGRAM_MEM_DATA_BITS-1:0] r_instr;
    logic [PROGRAM_MEM_DATA_BITS-1:0] w_next_instr;

    logic                             w_fetch_req;
    logic                             w_resp;
    logic                             w_hit;
    logic [PROGRAM_MEM_DATA_BITS-1:0] w_hit_data;

    assign w_fetch_req = (core_state == CS_FETCH);
    // A response only counts while our own request is outstanding.
    assign w_resp      = (r_state == FS_FETCHING) && r_valid && mem_read_ready;

`ifdef FETCHER_ICACHE_EN
    fetcher_icache #(
        .ADDR_BITS (PROGRAM_MEM_ADDR_BITS),
        .DATA_BITS (PROGRAM_MEM_DATA_BITS),
        .ENTRIES   (ICACHE_ENTRIES)
    ) u_icache (
        .clk         (clk),
        .reset       (reset),
        .i_lookup_pc (current_pc),
        .o_hit       (w_hit),
        .o_data      (w_hit_data),
        .i_fill_we   (w_resp),
        .i_fill_pc   (r_addr),
        .i_fill_data (mem_read_data)
    );
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = '0;

    // Cache geometry only matters with the cache built in; referenced here so both builds share one interface.
    if (ICACHE_ENTRIES < 2) begin : g_icache_absent
    end
`endif

    assign fetcher_state    = r_state;
    assign mem_read_valid   = r_valid;
    assign mem_read_address = r_addr;
    assign instruction      = r_instr;

    // State and output registers; reset abandons any outstanding request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FS_IDLE;
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_instr <= '0;
        end else begin
            r_state <= w_next_state;
            r_valid <= w_next_valid;
            r_addr  <= w_next_addr;
            r_instr <= w_next_instr;
        end
    end

    // Next-state and next-output decode; everything holds unless a rule below fires.
    always_comb begin
        w_next_state = r_state;
        w_next_valid = r_valid;
        w_next_addr  = r_addr;
        w_next_instr = r_instr;
        case (r_state)
            FS_IDLE: begin
                if (w_fetch_req) begin
                    if (w_hit) begin
                        w_next_instr = w_hit_data;
                        w_next_state = FS_FETCHED;
                    end else begin
                        w_next_addr  = current_pc;
                        w_next_valid = 1'b1;
                        w_next_state = FS_FETCHING;
                    end
                end
            end
            FS_FETCHING: begin
                if (w_resp) begin
                    w_next_instr = mem_read_data;
                    w_next_valid = 1'b0;
                    w_next_state = FS_FETCHED;
                end
            end
            FS_FETCHED: begin
                if (!w_fetch_req) begin
                    w_next_state = FS_IDLE;
                end
            end
            default: begin
                w_next_state = FS_IDLE;
                w_next_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fetcher.sv
// tb/tb_fetcher.sv - self-checking bench for fetcher: vector table, corner sequences, randomized model compare
module tb_fetcher;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int NE = 4;

    localparam logic [2:0] C_IDLE   = 3'b000;
    localparam logic [2:0] C_FETCH  = 3'b001;
    localparam logic [2:0] C_DECODE = 3'b010;

    localparam logic [2:0] S_IDLE     = 3'b000;
    localparam logic [2:0] S_FETCHING = 3'b001;
    localparam logic [2:0] S_FETCHED  = 3'b010;

`ifdef FETCHER_ICACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    core_state;
    logic [AW-1:0] current_pc;
    logic          mem_read_valid;
    logic [AW-1:0] mem_read_address;
    logic          mem_read_ready;
    logic [DW-1:0] mem_read_data;
    logic [2:0]    fetcher_state;
    logic [DW-1:0] instruction;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetcher #(
        .PROGRAM_MEM_ADDR_BITS (AW),
        .PROGRAM_MEM_DATA_BITS (DW),
        .ICACHE_ENTRIES        (NE)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .core_state       (core_state),
        .current_pc       (current_pc),
        .mem_read_valid   (mem_read_valid),
        .mem_read_address (mem_read_address),
        .mem_read_ready   (mem_read_ready),
        .mem_read_data    (mem_read_data),
        .fetcher_state    (fetcher_state),
        .instruction      (instruction)
    );

    typedef struct {
        logic          rst;
        logic [2:0]    cs;
        logic [AW-1:0] pc;
        logic          rdy;
        logic [DW-1:0] data;
        logic [2:0]    e_st;
        logic          e_v;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_i;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [2:0] cs, input logic [AW-1:0] pc,
                         input logic rd, input logic [DW-1:0] d);
        reset          = r;
        core_state     = cs;
        current_pc     = pc;
        mem_read_ready = rd;
        mem_read_data  = d;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [2:0] st, input logic v,
                              input logic [AW-1:0] a, input logic [DW-1:0] i);
        chk({tag, " state"}, 32'(fetcher_state), 32'(st));
        chk({tag, " valid"}, 32'(mem_read_valid), 32'(v));
        chk({tag, " addr"},  32'(mem_read_address), 32'(a));
        chk({tag, " instr"}, 32'(instruction), 32'(i));
    endtask

    task automatic add(input logic r, input logic [2:0] cs, input logic [AW-1:0] pc, input logic rd,
                       input logic [DW-1:0] d, input logic [2:0] st, input logic v,
                       input logic [AW-1:0] a, input logic [DW-1:0] i);
        vec_t t;
        t.rst = r; t.cs = cs; t.pc = pc; t.rdy = rd; t.data = d;
        t.e_st = st; t.e_v = v; t.e_a = a; t.e_i = i;
        vecs.push_back(t);
    endtask

    // Reference model state for the randomized phase
    int            m_phase;
    logic          m_v;
    logic [AW-1:0] m_a;
    logic [DW-1:0] m_i;
    logic          mc_valid [NE];
    logic [AW-1:0] mc_pc    [NE];
    logic [DW-1:0] mc_data  [NE];

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // inputs -> outputs after the next edge
        add(1, C_IDLE,   8'h00, 0, 16'h0000, S_IDLE,     0, 8'h00, 16'h0000);
        add(1, C_IDLE,   8'h00, 0, 16'h0000, S_IDLE,     0, 8'h00, 16'h0000);
        add(0, C_IDLE,   8'h33, 1, 16'hFFFF, S_IDLE,     0, 8'h00, 16'h0000);
        add(0, C_FETCH,  8'h05, 0, 16'h0000, S_FETCHING, 1, 8'h05, 16'h0000);
        add(0, C_FETCH,  8'h07, 0, 16'h0000, S_FETCHING, 1, 8'h05, 16'h0000);
        add(0, C_FETCH,  8'h07, 0, 16'h0000, S_FETCHING, 1, 8'h05, 16'h0000);
        add(0, C_FETCH,  8'h07, 1, 16'h1234, S_FETCHED,  0, 8'h05, 16'h1234);
        add(0, C_FETCH,  8'h09, 0, 16'h0000, S_FETCHED,  0, 8'h05, 16'h1234);
        add(0, C_FETCH,  8'h09, 1, 16'hFFFF, S_FETCHED,  0, 8'h05, 16'h1234);
        add(0, C_DECODE, 8'h09, 0, 16'h0000, S_IDLE,     0, 8'h05, 16'h1234);
        add(0, C_DECODE, 8'h09, 1, 16'hFFFF, S_IDLE,     0, 8'h05, 16'h1234);
        add(0, C_FETCH,  8'h10, 0, 16'h0000, S_FETCHING, 1, 8'h10, 16'h1234);
        add(0, C_FETCH,  8'h10, 1, 16'hA5A5, S_FETCHED,  0, 8'h10, 16'hA5A5);
        add(0, C_DECODE, 8'h10, 0, 16'h0000, S_IDLE,     0, 8'h10, 16'hA5A5);
        add(0, C_FETCH,  8'h00, 0, 16'h0000, S_FETCHING, 1, 8'h00, 16'hA5A5);
        add(0, C_FETCH,  8'h00, 1, 16'h0001, S_FETCHED,  0, 8'h00, 16'h0001);
        add(0, C_DECODE, 8'h00, 0, 16'h0000, S_IDLE,     0, 8'h00, 16'h0001);
        add(0, C_FETCH,  8'h01, 0, 16'h0000, S_FETCHING, 1, 8'h01, 16'h0001);
        add(0, C_FETCH,  8'h01, 1, 16'h0002, S_FETCHED,  0, 8'h01, 16'h0002);
        add(0, C_DECODE, 8'h01, 0, 16'h0000, S_IDLE,     0, 8'h01, 16'h0002);
        add(0, C_FETCH,  8'hFF, 0, 16'h0000, S_FETCHING, 1, 8'hFF, 16'h0002);
        add(0, C_FETCH,  8'hFF, 1, 16'h00FF, S_FETCHED,  0, 8'hFF, 16'h00FF);
        add(0, C_DECODE, 8'hFF, 0, 16'h0000, S_IDLE,     0, 8'hFF, 16'h00FF);
        add(0, C_FETCH,  8'h20, 0, 16'h0000, S_FETCHING, 1, 8'h20, 16'h00FF);
        add(1, C_FETCH,  8'h20, 0, 16'h0000, S_IDLE,     0, 8'h00, 16'h0000);
        add(0, C_IDLE,   8'h20, 1, 16'hBEEF, S_IDLE,     0, 8'h00, 16'h0000);
        add(0, C_IDLE,   8'h20, 0, 16'h0000, S_IDLE,     0, 8'h00, 16'h0000);

        drive(1, C_IDLE, 8'h00, 0, 16'h0000);
        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].rst, vecs[k].cs, vecs[k].pc, vecs[k].rdy, vecs[k].data);
            tick();
            expect_out($sformatf("vec%0d", k), vecs[k].e_st, vecs[k].e_v, vecs[k].e_a, vecs[k].e_i);
        end

        // Repeat fetch of one PC, then a same-index different-tag PC
        drive(1, C_IDLE, 8'h00, 0, 16'h0000); tick();
        drive(0, C_FETCH, 8'h02, 0, 16'h0000); tick();
        expect_out("rep first req", S_FETCHING, 1, 8'h02, 16'h0000);
        drive(0, C_FETCH, 8'h02, 1, 16'h0202); tick();
        expect_out("rep first done", S_FETCHED, 0, 8'h02, 16'h0202);
        drive(0, C_DECODE, 8'h02, 0, 16'h0000); tick();
        chk("rep idle state", 32'(fetcher_state), 32'(S_IDLE));
        drive(0, C_FETCH, 8'h02, 0, 16'h0000); tick();
`ifdef FETCHER_ICACHE_EN
        chk("rep hit state", 32'(fetcher_state), 32'(S_FETCHED));
        chk("rep hit valid", 32'(mem_read_valid), 32'(1'b0));
        chk("rep hit instr", 32'(instruction), 32'h0202);
`else
        expect_out("rep second req", S_FETCHING, 1, 8'h02, 16'h0202);
        drive(0, C_FETCH, 8'h02, 1, 16'h0202); tick();
        expect_out("rep second done", S_FETCHED, 0, 8'h02, 16'h0202);
`endif
        drive(0, C_DECODE, 8'h02, 0, 16'h0000); tick();
        chk("rep idle2 state", 32'(fetcher_state), 32'(S_IDLE));
        drive(0, C_FETCH, 8'h06, 0, 16'h0000); tick();
        chk("alias req state", 32'(fetcher_state), 32'(S_FETCHING));
        chk("alias req valid", 32'(mem_read_valid), 32'(1'b1));
        chk("alias req addr", 32'(mem_read_address), 32'h06);
        drive(0, C_FETCH, 8'h06, 1, 16'h0606); tick();
        chk("alias done state", 32'(fetcher_state), 32'(S_FETCHED));
        chk("alias done instr", 32'(instruction), 32'h0606);
        drive(0, C_DECODE, 8'h06, 0, 16'h0000); tick();

        // Randomized traffic against the reference model
        m_phase = 0; m_v = 0; m_a = '0; m_i = '0;
        for (int e = 0; e < NE; e++) begin
            mc_valid[e] = 0; mc_pc[e] = '0; mc_data[e] = '0;
        end
        for (int n = 0; n < 400; n++) begin
            logic          r;
            logic [2:0]    cs;
            logic [AW-1:0] pc;
            logic          rd;
            logic [DW-1:0] d;
            logic          hit;
            int            idx;
            r  = (n == 0) || ($urandom_range(0, 99) < 3);
            cs = ($urandom_range(0, 1) == 1) ? C_FETCH : 3'($urandom_range(0, 7));
            pc = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 11));
            rd = ($urandom_range(0, 99) < 40);
            d  = 16'($urandom);
            drive(r, cs, pc, rd, d);
            if (r) begin
                m_phase = 0; m_v = 0; m_a = '0; m_i = '0;
                for (int e = 0; e < NE; e++) mc_valid[e] = 0;
            end else if (m_phase == 0) begin
                if (cs == C_FETCH) begin
                    idx = int'(pc) % NE;
                    hit = CACHE_ON && mc_valid[idx] && (mc_pc[idx] == pc);
                    if (hit) begin
                        m_i = mc_data[idx];
                        m_phase = 2;
                    end else begin
                        m_a = pc;
                        m_v = 1;
                        m_phase = 1;
                    end
                end
            end else if (m_phase == 1) begin
                if (rd) begin
                    m_i = d;
                    m_v = 0;
                    m_phase = 2;
                    idx = int'(m_a) % NE;
                    mc_valid[idx] = 1;
                    mc_pc[idx]    = m_a;
                    mc_data[idx]  = d;
                end
            end else begin
                if (cs != C_FETCH) m_phase = 0;
            end
            tick();
            expect_out($sformatf("rnd%0d", n), 3'(m_phase), m_v, m_a, m_i);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
